spi_mem_responder: RTL



---
 rtl/spi_mem_pkg.sv | 9 +
 rtl/spi_input_sync.sv | 32 +++
 rtl/spi_mem_responder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/spi_mem_pkg.sv
// Shared opcodes, FSM state encoding and address framing for the SPI memory responder.
package spi_mem_pkg;
    localparam logic [7:0] OPC_READ   = 8'h03;
    localparam logic [7:0] OPC_WRITE  = 8'h02;
    localparam int         ADDR_BITS  = 24;
    localparam int         ADDR_BYTES = ADDR_BITS / 8;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, RD, WR, IGNORE} state_t;
endpackage

// File: rtl/spi_input_sync.sv
// Two-flop synchronizer for sclk/mosi/cs plus a delayed sclk copy for edge detection.
// Only instantiated when SPI_SYNC_EN is defined.
module spi_input_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic mosi,
    input  logic cs,
    output logic sclk_s,
    output logic mosi_s,
    output logic cs_s,
    output logic sclk_d
);
    // bit order {cs, mosi, sclk}; cs idles high
    logic [1:0][2:0] sync_pipe;
    logic            sclk_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_pipe <= {2{3'b100}};
            sclk_q    <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], {cs, mosi, sclk}};
            sclk_q    <= sync_pipe[1][0];
        end
    end

    assign sclk_s = sync_pipe[1][0];
    assign mosi_s = sync_pipe[1][1];
    assign cs_s   = sync_pipe[1][2];
    assign sclk_d = sclk_q;
endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 memory responder: READ/WRITE with 24-bit address served from an internal byte array.
// Define SPI_SYNC_EN to pass sclk/mosi/cs through 2-flop synchronizers (adds 2 clk latency).
module spi_mem_responder
    import spi_mem_pkg::*;
#(
    parameter  int DEPTH_BYTES = 256,
    localparam int AW          = $clog2(DEPTH_BYTES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sclk,
    input  logic          mosi,
    input  logic          cs,
    output logic          miso,
    output logic          busy,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata
);
    logic sclk_s, mosi_s, cs_s, sclk_d;

`ifdef SPI_SYNC_EN
    spi_input_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .sclk   (sclk),
        .mosi   (mosi),
        .cs     (cs),
        .sclk_s (sclk_s),
        .mosi_s (mosi_s),
        .cs_s   (cs_s),
        .sclk_d (sclk_d)
    );
`else
    assign sclk_s = sclk;
    assign mosi_s = mosi;
    assign cs_s   = cs;

    always_ff @(posedge clk) begin
        if (!rst_n) sclk_d <= 1'b0;
        else        sclk_d <= sclk_s;
    end
`endif

    logic cs_d;
    always_ff @(posedge clk) begin
        if (!rst_n) cs_d <= 1'b1;
        else        cs_d <= cs_s;
    end

    logic rise, fall, cs_fall;
    assign rise    =  sclk_s & ~sclk_d;
    assign fall    = ~sclk_s &  sclk_d;
    assign cs_fall =  cs_d   & ~cs_s;

    logic [7:0] mem [DEPTH_BYTES];

    state_t        state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [1:0]    byte_cnt, byte_cnt_n;
    logic [6:0]    shift_in, shift_in_n;
    logic [7:0]    shift_out, shift_out_n;
    logic [AW-1:0] addr, addr_n;
    logic          rd_op, rd_op_n;
    logic          miso_q, miso_n;
    logic          spi_we;

    logic [7:0]    in_byte;
    logic [AW-1:0] addr_in, addr_inc;
    assign in_byte  = {shift_in, mosi_s};
    // only the low AW bits of the 24-bit address survive the shift
    assign addr_in  = {addr[AW-2:0], mosi_s};
    assign addr_inc = addr + AW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            addr      <= '0;
            rd_op     <= 1'b0;
            miso_q    <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            byte_cnt  <= byte_cnt_n;
            shift_in  <= shift_in_n;
            shift_out <= shift_out_n;
            addr      <= addr_n;
            rd_op     <= rd_op_n;
            miso_q    <= miso_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        byte_cnt_n  = byte_cnt;
        shift_in_n  = shift_in;
        shift_out_n = shift_out;
        addr_n      = addr;
        rd_op_n     = rd_op;
        miso_n      = miso_q;
        spi_we      = 1'b0;
        if (cs_s) begin
            state_n    = IDLE;
            bit_cnt_n  = '0;
            byte_cnt_n = '0;
            miso_n     = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    miso_n = 1'b0;
                    if (cs_fall) begin
                        state_n    = CMD;
                        bit_cnt_n  = '0;
                        byte_cnt_n = '0;
                    end
                end
                CMD: if (rise) begin
                    shift_in_n = in_byte[6:0];
                    bit_cnt_n  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rd_op_n = (in_byte == OPC_READ);
                        state_n = (in_byte == OPC_READ || in_byte == OPC_WRITE) ? ADDR : IGNORE;
                    end
                end
                ADDR: if (rise) begin
                    addr_n    = addr_in;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_cnt_n = byte_cnt + 2'd1;
                        if (byte_cnt == 2'(ADDR_BYTES - 1)) begin
                            byte_cnt_n = '0;
                            if (rd_op) begin
                                state_n     = RD;
                                shift_out_n = mem[addr_in];
                            end else begin
                                state_n = WR;
                            end
                        end
                    end
                end
                RD: if (fall) begin
                    miso_n      = shift_out[7];
                    shift_out_n = {shift_out[6:0], 1'b0};
                    bit_cnt_n   = bit_cnt + 3'd1;
                    // prefetch the next byte so it is ready for the following fall
                    if (bit_cnt == 3'd7) begin
                        addr_n      = addr_inc;
                        shift_out_n = mem[addr_inc];
                    end
                end
                WR: if (rise) begin
                    shift_in_n = in_byte[6:0];
                    bit_cnt_n  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        spi_we = 1'b1;
                        addr_n = addr_inc;
                    end
                end
                IGNORE:  miso_n  = 1'b0;
                default: state_n = IDLE;
            endcase
        end
    end

    logic spi_commit;
    assign spi_commit = spi_we & rst_n;

    // array is deliberately not reset; an SPI write to the same address beats the host
    always_ff @(posedge clk) begin
        if (host_we && !(spi_commit && host_addr == addr))
            mem[host_addr] <= host_wdata;
        if (spi_commit)
            mem[addr] <= in_byte;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) host_rdata <= 8'h00;
        else        host_rdata <= mem[host_addr];
    end

    assign miso = miso_q;
    assign busy = (state != IDLE);
endmodule
